// File: rtl/axi_demux_pkg.sv
// ============================================================================
// Module   : axi_demux_pkg
// Purpose  : Shared helpers for the AXI demux ID tracker (select width,
//            ID-to-slot folding, signed per-cycle slot delta).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_demux_pkg;

    // Signed per-cycle slot delta: push + inject - pop, range -1..+2
    typedef logic signed [2:0] delta_t;

    function automatic int unsigned select_width(input int unsigned num_ports);
        return (num_ports > 1) ? unsigned'($clog2(num_ports)) : 1;
    endfunction

    // IDs fold onto slots by their low-order bits
    function automatic int unsigned slot_index(input logic [31:0] axi_id,
                                               input int unsigned slot_bits);
        return axi_id & ((32'd1 << slot_bits) - 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_demux_id_slot.sv
// ============================================================================
// Module   : axi_demux_id_slot
// Purpose  : One tracker slot: saturating in-flight counter, bound master
//            select, full/occupied flags and optional sticky error flag
//            (AXI_DEMUX_ID_TRACK_ERR_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_demux_id_slot
    import axi_demux_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 4,
    parameter int unsigned SELECT_WIDTH  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic                    inject_i,
    input  logic                    pop_i,
    input  logic [SELECT_WIDTH-1:0] push_select_i,
    output logic [SELECT_WIDTH-1:0] select_o,
    output logic                    occupied_o,
    output logic                    full_o,
    output logic                    err_o
);

    localparam logic [COUNTER_WIDTH-1:0] c_full_thresh = {{(COUNTER_WIDTH-1){1'b1}}, 1'b0};

    logic [COUNTER_WIDTH-1:0] r_count;
    logic [SELECT_WIDTH-1:0]  r_select;
    delta_t                   w_delta;
    logic [COUNTER_WIDTH+1:0] w_sum;
    logic                     w_underflow;
    logic                     w_overflow;
    logic [COUNTER_WIDTH-1:0] w_count_next;

    // Two guard bits above the counter make the sign and overflow directly visible
    always_comb begin
        w_delta      = delta_t'({2'b00, push_i}) + delta_t'({2'b00, inject_i})
                     - delta_t'({2'b00, pop_i});
        w_sum        = {2'b00, r_count} + {{(COUNTER_WIDTH-1){w_delta[2]}}, w_delta};
        w_underflow  = w_sum[COUNTER_WIDTH+1];
        w_overflow   = !w_sum[COUNTER_WIDTH+1] && w_sum[COUNTER_WIDTH];
        w_count_next = w_sum[COUNTER_WIDTH-1:0];
        if (w_underflow) begin
            w_count_next = '0;
        end else if (w_overflow) begin
            w_count_next = '1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count  <= '0;
            r_select <= '0;
        end else begin
            r_count <= w_count_next;
            if (push_i) begin
                r_select <= push_select_i;
            end
        end
    end

    assign select_o   = r_select;
    assign occupied_o = (r_count != '0);
    assign full_o     = (r_count >= c_full_thresh);

`ifdef AXI_DEMUX_ID_TRACK_ERR_EN
    logic r_err;
    logic w_err_event;

    assign w_err_event = (pop_i && (r_count == '0)) || w_overflow ||
                         (push_i && (r_count != '0) && (push_select_i != r_select));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_err_event) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/axi_demux_id_tracker.sv
// ============================================================================
// Module   : axi_demux_id_tracker
// Purpose  : Per-ID-slot in-flight tracker for the AXI demux with ID folding,
//            full/conflict lookup and saturating counters. Error detection
//            is compiled in with AXI_DEMUX_ID_TRACK_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_demux_id_tracker
    import axi_demux_pkg::*;
#(
    parameter  int unsigned AXI_ID_BITS   = 4,
    parameter  int unsigned SLOT_ID_BITS  = 2,
    parameter  int unsigned COUNTER_WIDTH = 4,
    parameter  int unsigned NO_MST_PORTS  = 3,
    localparam int unsigned SELECT_WIDTH  = select_width(NO_MST_PORTS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [AXI_ID_BITS-1:0]  lookup_axi_id_i,
    input  logic [SELECT_WIDTH-1:0] lookup_mst_select_i,
    output logic [SELECT_WIDTH-1:0] lookup_mst_select_o,
    output logic                    lookup_occupied_o,
    output logic                    lookup_full_o,
    output logic                    lookup_conflict_o,
    output logic                    any_full_o,
    input  logic [AXI_ID_BITS-1:0]  push_axi_id_i,
    input  logic [SELECT_WIDTH-1:0] push_mst_select_i,
    input  logic                    push_i,
    input  logic [AXI_ID_BITS-1:0]  inject_axi_id_i,
    input  logic                    inject_i,
    input  logic [AXI_ID_BITS-1:0]  pop_axi_id_i,
    input  logic                    pop_i,
    output logic                    err_o
);

    localparam int unsigned c_num_slots = 2 ** SLOT_ID_BITS;

    logic [SLOT_ID_BITS-1:0] w_push_slot;
    logic [SLOT_ID_BITS-1:0] w_inject_slot;
    logic [SLOT_ID_BITS-1:0] w_pop_slot;
    logic [SLOT_ID_BITS-1:0] w_lookup_slot;
    logic [SELECT_WIDTH-1:0] w_slot_select [c_num_slots];
    logic [c_num_slots-1:0]  w_slot_occupied;
    logic [c_num_slots-1:0]  w_slot_full;
    logic [c_num_slots-1:0]  w_slot_err;
    logic                    w_unused_id_bits;

    assign w_push_slot   = SLOT_ID_BITS'(slot_index(32'(push_axi_id_i),   SLOT_ID_BITS));
    assign w_inject_slot = SLOT_ID_BITS'(slot_index(32'(inject_axi_id_i), SLOT_ID_BITS));
    assign w_pop_slot    = SLOT_ID_BITS'(slot_index(32'(pop_axi_id_i),    SLOT_ID_BITS));
    assign w_lookup_slot = SLOT_ID_BITS'(slot_index(32'(lookup_axi_id_i), SLOT_ID_BITS));

    // Upper ID bits are folded away by design
    assign w_unused_id_bits = ^{push_axi_id_i, inject_axi_id_i, pop_axi_id_i, lookup_axi_id_i};

    for (genvar s = 0; s < c_num_slots; s++) begin : g_slot
        axi_demux_id_slot #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .SELECT_WIDTH  (SELECT_WIDTH)
        ) u_slot (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .push_i        (push_i   && (w_push_slot   == SLOT_ID_BITS'(s))),
            .inject_i      (inject_i && (w_inject_slot == SLOT_ID_BITS'(s))),
            .pop_i         (pop_i    && (w_pop_slot    == SLOT_ID_BITS'(s))),
            .push_select_i (push_mst_select_i),
            .select_o      (w_slot_select[s]),
            .occupied_o    (w_slot_occupied[s]),
            .full_o        (w_slot_full[s]),
            .err_o         (w_slot_err[s])
        );
    end

    // Lookup reads registered state only; same-cycle updates show up next cycle
    assign lookup_mst_select_o = w_slot_select[w_lookup_slot];
    assign lookup_occupied_o   = w_slot_occupied[w_lookup_slot];
    assign lookup_full_o       = w_slot_full[w_lookup_slot];
    assign lookup_conflict_o   = lookup_occupied_o && (lookup_mst_select_o != lookup_mst_select_i);
    assign any_full_o          = |w_slot_full;
    assign err_o               = |w_slot_err;

endmodule

`default_nettype wire

// File: tb/tb_axi_demux_id_tracker.sv
// ============================================================================
// Module   : tb_axi_demux_id_tracker
// Purpose  : Self-checking bench: directed vector table, hand-written corner
//            sequences and randomized traffic against a count/select model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_demux_id_tracker;

`ifdef AXI_DEMUX_ID_TRACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int MAXC = 15;
    localparam int FULLC = 14;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] lookup_axi_id_i;
    logic [1:0] lookup_mst_select_i;
    logic [1:0] lookup_mst_select_o;
    logic       lookup_occupied_o, lookup_full_o, lookup_conflict_o, any_full_o;
    logic [3:0] push_axi_id_i, inject_axi_id_i, pop_axi_id_i;
    logic [1:0] push_mst_select_i;
    logic       push_i, inject_i, pop_i, err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    axi_demux_id_tracker #(
        .AXI_ID_BITS   (4),
        .SLOT_ID_BITS  (2),
        .COUNTER_WIDTH (4),
        .NO_MST_PORTS  (3)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .lookup_axi_id_i     (lookup_axi_id_i),
        .lookup_mst_select_i (lookup_mst_select_i),
        .lookup_mst_select_o (lookup_mst_select_o),
        .lookup_occupied_o   (lookup_occupied_o),
        .lookup_full_o       (lookup_full_o),
        .lookup_conflict_o   (lookup_conflict_o),
        .any_full_o          (any_full_o),
        .push_axi_id_i       (push_axi_id_i),
        .push_mst_select_i   (push_mst_select_i),
        .push_i              (push_i),
        .inject_axi_id_i     (inject_axi_id_i),
        .inject_i            (inject_i),
        .pop_axi_id_i        (pop_axi_id_i),
        .pop_i               (pop_i),
        .err_o               (err_o)
    );

    typedef struct {
        bit       push;   logic [3:0] push_id; logic [1:0] push_sel;
        bit       inject; logic [3:0] inj_id;
        bit       pop;    logic [3:0] pop_id;
        logic [3:0] lk_id; logic [1:0] lk_sel;
        bit e_occ; logic [1:0] e_sel; bit e_full; bit e_conf; bit e_anyfull; bit e_err;
    } vec_t;

    vec_t vecs [13];

    // Reference model: plain per-slot integers
    int  m_cnt [4];
    int  m_sel [4];
    bit  m_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_ops();
        push_i = 1'b0; inject_i = 1'b0; pop_i = 1'b0;
        push_axi_id_i = '0; inject_axi_id_i = '0; pop_axi_id_i = '0; push_mst_select_i = '0;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            m_cnt[s] = 0;
            m_sel[s] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit p, input int pid, input int psel,
                              input bit j, input int jid, input bit q, input int qid);
        for (int s = 0; s < 4; s++) begin
            int ps, js, qs, n;
            ps = (p && (pid % 4) == s) ? 1 : 0;
            js = (j && (jid % 4) == s) ? 1 : 0;
            qs = (q && (qid % 4) == s) ? 1 : 0;
            n  = m_cnt[s] + ps + js - qs;
            if (qs == 1 && m_cnt[s] == 0) m_err = ERR_EN;
            if (ps == 1 && m_cnt[s] != 0 && psel != m_sel[s]) m_err = ERR_EN;
            if (n > MAXC) begin
                n = MAXC;
                m_err = ERR_EN;
            end
            if (n < 0) n = 0;
            m_cnt[s] = n;
            if (ps == 1) m_sel[s] = psel;
        end
    endtask

    task automatic model_check(input string tag);
        int s;
        bit af;
        s  = int'(lookup_axi_id_i) % 4;
        af = 1'b0;
        for (int k = 0; k < 4; k++) if (m_cnt[k] >= FULLC) af = 1'b1;
        chk({tag, " occupied"}, lookup_occupied_o, m_cnt[s] != 0);
        chk({tag, " full"}, lookup_full_o, m_cnt[s] >= FULLC);
        chk({tag, " conflict"}, lookup_conflict_o, (m_cnt[s] != 0) && (m_sel[s] != int'(lookup_mst_select_i)));
        if (m_cnt[s] != 0) chk({tag, " select"}, lookup_mst_select_o, m_sel[s]);
        chk({tag, " any_full"}, any_full_o, af);
        chk({tag, " err"}, err_o, m_err);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_ops();
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;
    endtask

    task automatic cycle_ops(input bit p, input logic [3:0] pid, input logic [1:0] psel,
                             input bit j, input logic [3:0] jid, input bit q, input logic [3:0] qid);
        push_i = p; push_axi_id_i = pid; push_mst_select_i = psel;
        inject_i = j; inject_axi_id_i = jid;
        pop_i = q; pop_axi_id_i = qid;
        @(posedge clk_i);
        #1 clear_ops();
    endtask

    task automatic look(input logic [3:0] id, input logic [1:0] sel);
        lookup_axi_id_i = id;
        lookup_mst_select_i = sel;
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        clear_ops();
        lookup_axi_id_i = '0;
        lookup_mst_select_i = '0;

        //            push id   sel  inj id   pop id    lk   lsel occ sel full conf af err
        vecs[0]  = '{0, 4'h0, 2'd0, 0, 4'h0, 0, 4'h0, 4'h0, 2'd0, 0, 2'd0, 0, 0, 0, 0};
        vecs[1]  = '{1, 4'h5, 2'd2, 0, 4'h0, 0, 4'h0, 4'h1, 2'd2, 1, 2'd2, 0, 0, 0, 0};
        vecs[2]  = '{0, 4'h0, 2'd0, 0, 4'h0, 0, 4'h0, 4'h1, 2'd1, 1, 2'd2, 0, 1, 0, 0};
        vecs[3]  = '{1, 4'h2, 2'd1, 1, 4'h6, 0, 4'h0, 4'h2, 2'd1, 1, 2'd1, 0, 0, 0, 0};
        vecs[4]  = '{0, 4'h0, 2'd0, 0, 4'h0, 1, 4'h2, 4'h2, 2'd1, 1, 2'd1, 0, 0, 0, 0};
        vecs[5]  = '{0, 4'h0, 2'd0, 0, 4'h0, 1, 4'hA, 4'h2, 2'd0, 0, 2'd1, 0, 0, 0, 0};
        vecs[6]  = '{1, 4'h3, 2'd0, 1, 4'h3, 0, 4'h0, 4'h3, 2'd0, 1, 2'd0, 0, 0, 0, 0};
        vecs[7]  = '{1, 4'hB, 2'd0, 0, 4'h0, 0, 4'h0, 4'h3, 2'd0, 1, 2'd0, 0, 0, 0, 0};
        vecs[8]  = '{1, 4'h7, 2'd2, 0, 4'h0, 1, 4'h3, 4'h3, 2'd2, 1, 2'd2, 0, 0, 0, 1};
        vecs[9]  = '{0, 4'h0, 2'd0, 0, 4'h0, 1, 4'h3, 4'h3, 2'd1, 1, 2'd2, 0, 1, 0, 1};
        vecs[10] = '{0, 4'h0, 2'd0, 0, 4'h0, 1, 4'hF, 4'h3, 2'd2, 1, 2'd2, 0, 0, 0, 1};
        vecs[11] = '{0, 4'h0, 2'd0, 0, 4'h0, 1, 4'h3, 4'h3, 2'd1, 0, 2'd2, 0, 0, 0, 1};
        vecs[12] = '{0, 4'h0, 2'd0, 0, 4'h0, 1, 4'h1, 4'h1, 2'd0, 0, 2'd2, 0, 0, 0, 1};

        do_reset();
        look(4'h0, 2'd0);
        chk("reset occupied", lookup_occupied_o, 0);
        chk("reset select", lookup_mst_select_o, 0);
        chk("reset any_full", any_full_o, 0);
        chk("reset err", err_o, 0);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cycle_ops(vecs[i].push, vecs[i].push_id, vecs[i].push_sel,
                      vecs[i].inject, vecs[i].inj_id, vecs[i].pop, vecs[i].pop_id);
            look(vecs[i].lk_id, vecs[i].lk_sel);
            chk({tag, " occupied"}, lookup_occupied_o, vecs[i].e_occ);
            chk({tag, " select"}, lookup_mst_select_o, vecs[i].e_sel);
            chk({tag, " full"}, lookup_full_o, vecs[i].e_full);
            chk({tag, " conflict"}, lookup_conflict_o, vecs[i].e_conf);
            chk({tag, " any_full"}, any_full_o, vecs[i].e_anyfull);
            chk({tag, " err"}, err_o, vecs[i].e_err && ERR_EN);
        end

        // Fill slot 2 to the full threshold and past saturation
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            cycle_ops(1, 4'h2, 2'd0, 0, 4'h0, 0, 4'h0);
            look(4'h6, 2'd0);
            if (n == 13 || n == 14 || n == 16) begin
                chk($sformatf("fill%0d full", n), lookup_full_o, n >= FULLC);
                chk($sformatf("fill%0d any_full", n), any_full_o, n >= FULLC);
                chk($sformatf("fill%0d err", n), err_o, (n == 16) && ERR_EN);
            end
        end
        for (int n = 1; n <= 15; n++) begin
            cycle_ops(0, 4'h0, 2'd0, 0, 4'h0, 1, 4'h2);
            look(4'h2, 2'd0);
            if (n == 1)  chk("drain1 full", lookup_full_o, 1);
            if (n == 2)  chk("drain2 full", lookup_full_o, 0);
            if (n >= 14) chk($sformatf("drain%0d occupied", n), lookup_occupied_o, n < 15);
        end

        // Pop on an empty slot must not wrap the counter
        do_reset();
        cycle_ops(0, 4'h0, 2'd0, 0, 4'h0, 1, 4'h1);
        look(4'h1, 2'd0);
        chk("popempty occupied", lookup_occupied_o, 0);
        chk("popempty full", lookup_full_o, 0);
        chk("popempty err", err_o, ERR_EN);
        cycle_ops(1, 4'h9, 2'd1, 0, 4'h0, 0, 4'h0);
        look(4'h1, 2'd1);
        chk("popempty push occupied", lookup_occupied_o, 1);
        chk("popempty push full", lookup_full_o, 0);
        cycle_ops(0, 4'h0, 2'd0, 0, 4'h0, 1, 4'h1);
        look(4'h1, 2'd1);
        chk("popempty drain occupied", lookup_occupied_o, 0);

        // Asynchronous reset with three slots occupied
        do_reset();
        cycle_ops(1, 4'h0, 2'd1, 0, 4'h0, 0, 4'h0);
        cycle_ops(1, 4'h1, 2'd2, 0, 4'h0, 0, 4'h0);
        cycle_ops(1, 4'h2, 2'd1, 1, 4'h2, 0, 4'h0);
        look(4'h1, 2'd2);
        chk("pre-reset occupied", lookup_occupied_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) begin
            look(4'(s), 2'd1);
            chk($sformatf("async rst slot%0d occupied", s), lookup_occupied_o, 0);
            chk($sformatf("async rst slot%0d select", s), lookup_mst_select_o, 0);
            chk($sformatf("async rst slot%0d conflict", s), lookup_conflict_o, 0);
            chk($sformatf("async rst slot%0d full", s), lookup_full_o, 0);
        end
        chk("async rst any_full", any_full_o, 0);
        chk("async rst err", err_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Randomized traffic: push-heavy single-select phase, then mixed
        for (int phase = 0; phase < 2; phase++) begin
            do_reset();
            model_reset();
            @(posedge clk_i);
            #1;
            for (int c = 0; c < 400; c++) begin
                bit p, j, q;
                int pid, psel, jid, qid;
                if (phase == 0) begin
                    p = ($urandom_range(0, 3) != 0);
                    q = ($urandom_range(0, 3) == 0);
                    psel = 0;
                end else begin
                    p = $urandom_range(0, 1);
                    q = $urandom_range(0, 1);
                    psel = $urandom_range(0, 2);
                end
                j   = ($urandom_range(0, 3) == 0);
                pid = $urandom_range(0, 15);
                jid = $urandom_range(0, 15);
                qid = $urandom_range(0, 15);
                push_i = p; push_axi_id_i = 4'(pid); push_mst_select_i = 2'(psel);
                inject_i = j; inject_axi_id_i = 4'(jid);
                pop_i = q; pop_axi_id_i = 4'(qid);
                lookup_axi_id_i = 4'($urandom_range(0, 15));
                lookup_mst_select_i = 2'($urandom_range(0, 2));
                #1;
                model_check($sformatf("rnd%0d.%0d", phase, c));
                @(posedge clk_i);
                model_step(p, pid, psel, j, jid, q, qid);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
